// File: rtl/adder_share_sched_pkg.sv
// ----------------------------------------------------------------------------
// adder_share_pkg : shared widths and tag type for the adder-sharing scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package adder_share_pkg;

  localparam int DW_DEFAULT  = 8;
  localparam int NUM_REQ_MAX = 8;
  localparam int ID_W        = $clog2(NUM_REQ_MAX);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/adder_share_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin grant, search starts at ptr_i+1
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o
);

  logic found;
  int   cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && elig_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = ID_W'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/adder_share_sched.sv
// ----------------------------------------------------------------------------
// adder_share_sched : round-robin time-sharing of one external adder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder_share_sched
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = DW_DEFAULT,
  parameter int ADD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*DW-1:0] req_a_i,
  input  logic [NUM_REQ*DW-1:0] req_b_i,
  output logic [DW-1:0]         add_a_o,
  output logic [DW-1:0]         add_b_o,
  output logic                  add_valid_o,
  input  logic [DW-1:0]         add_x_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [NUM_REQ*DW-1:0] rsp_data_o
);

  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    busy_q, busy_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DW-1:0] rsp_data_q, rsp_data_d;
  logic [DW-1:0]         add_a_q, add_a_d;
  logic [DW-1:0]         add_b_q, add_b_d;
  tag_t                  tag_q [0:ADD_LAT];
  tag_t                  tag_d [0:ADD_LAT];

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  accept;

  assign elig = req_valid_i & ~busy_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  assign accept      = reset & (|grant);
  assign req_ready_o = reset ? grant : '0;

  always_comb begin
    ptr_d       = accept ? grant_idx : ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    // tag_q[0] travels with the operands; tag_q[ADD_LAT] lines up with add_x_i
    tag_d[0].v  = accept;
    tag_d[0].id = grant_idx;
    for (int k = 1; k <= ADD_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && grant[i]) begin
        add_a_d   = req_a_i[i*DW +: DW];
        add_b_d   = req_b_i[i*DW +: DW];
        busy_d[i] = 1'b1;
      end
      if (rsp_valid_q[i] && rsp_ready_i[i]) begin
        rsp_valid_d[i] = 1'b0;
        busy_d[i]      = 1'b0;
      end
      if (tag_q[ADD_LAT].v && (tag_q[ADD_LAT].id == ID_W'(i))) begin
        rsp_valid_d[i]          = 1'b1;
        rsp_data_d[i*DW +: DW]  = add_x_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      busy_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      for (int k = 0; k <= ADD_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      for (int k = 0; k <= ADD_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign add_a_o     = add_a_q;
  assign add_b_o     = add_b_q;
  assign add_valid_o = tag_q[0].v;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

`default_nettype wire
